// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer.
// Holds the opcode map, FSM state encoding and datapath defaults.
package alu_pkg;

  localparam int DW_DEF  = 8;
  localparam int OPW_DEF = 4;

  localparam int OP_NOP    = 0;
  localparam int OP_LOAD_A = 1;
  localparam int OP_LOAD_B = 2;
  localparam int OP_ADD    = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/alu_sequencer_cmd_fifo.sv
// Command FIFO: DEPTH entries of W bits, first-word-fall-through head.
// Ports: i_clk, i_rst (sync, active-high), i_push/i_data, i_pop,
//        o_full, o_empty, o_head.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command front-end for the ALU: buffers host commands, issues them
// on alu_inst/alu_in, and returns ADD results on a valid/ready port.
// Ports: clock, reset (sync, active-high); cmd_valid/ready/op/data in;
//        alu_inst/alu_in out, alu_ret in; res_valid/ready/data out;
//        cmd_err pulse on illegal opcode; busy.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = DW_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [OPW-1:0] cmd_op,
  input  logic [DW-1:0]  cmd_data,
  output logic [OPW-1:0] alu_inst,
  output logic [DW-1:0]  alu_in,
  input  logic [DW-1:0]  alu_ret,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [DW-1:0]  res_data,
  output logic           cmd_err,
  output logic           busy
);

  localparam logic [OPW-1:0] C_NOP = OPW'(OP_NOP);
  localparam logic [OPW-1:0] C_ADD = OPW'(OP_ADD);

  logic [1:0]        r_state;
  logic [OPW-1:0]    r_inst;
  logic [DW-1:0]     r_in;
  logic              r_res_valid;
  logic [DW-1:0]     r_res_data;
  logic              r_err;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [OPW+DW-1:0] w_head;
  logic [OPW-1:0]    w_op;
  logic [DW-1:0]     w_data;
  logic              w_legal;
  logic              w_go;

  assign w_push  = cmd_valid && !w_full;
  assign w_op    = w_head[OPW+DW-1:DW];
  assign w_data  = w_head[DW-1:0];
  assign w_legal = (w_op <= C_ADD);
  assign w_go    = w_legal && (w_op != C_NOP);

  // A pending ADD must drain through WAIT/HOLD before the next pop.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) ||
                  ((r_state == ST_ISSUE) && (r_inst != C_ADD)));

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (OPW + DW)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_data  ({cmd_op, cmd_data}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_inst      <= '0;
      r_in        <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_ISSUE: begin
          if (w_pop) begin
            if (w_go) begin
              r_inst  <= w_op;
              r_in    <= (w_op == C_ADD) ? '0 : w_data;
              r_state <= ST_ISSUE;
            end else begin
              r_inst  <= '0;
              r_in    <= '0;
              r_err   <= !w_legal;
              r_state <= ST_IDLE;
            end
          end else if ((r_state == ST_ISSUE) && (r_inst == C_ADD)) begin
            r_inst  <= '0;
            r_in    <= '0;
            r_state <= ST_WAIT;
          end else begin
            r_inst  <= '0;
            r_in    <= '0;
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          r_res_data  <= alu_ret;
          r_res_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        default: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign cmd_ready = !w_full;
  assign alu_inst  = r_inst;
  assign alu_in    = r_in;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign cmd_err   = r_err;
  assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer paired with a small registered ALU model.
// Directed scenarios followed by randomized commands vs a reference model.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = '0;
  logic [7:0] cmd_data = '0;
  logic [3:0] alu_inst;
  logic [7:0] alu_in;
  logic [7:0] alu_ret;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       cmd_err;
  logic       busy;

  logic rr_mode = 1'b0;
  logic rr_val  = 1'b1;
  logic rnd_bit = 1'b0;
  assign res_ready = rr_mode ? rnd_bit : rr_val;

  always #5 clock = ~clock;

  alu_sequencer #(.DEPTH(4), .DW(8), .OPW(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .alu_inst  (alu_inst),
    .alu_in    (alu_in),
    .alu_ret   (alu_ret),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  // ALU: A/B load registers and a registered sum.
  logic [7:0] alu_a = '0;
  logic [7:0] alu_b = '0;
  logic [7:0] alu_r = '0;
  assign alu_ret = alu_r;
  always @(posedge clock) begin
    case (alu_inst)
      4'd1:    alu_a <= alu_in;
      4'd2:    alu_b <= alu_in;
      4'd3:    alu_r <= alu_a + alu_b;
      default: ;
    endcase
  end

  // Observed traffic, sampled on the falling edge.
  logic [11:0] iss_q[$];
  int          iss_cyc[$];
  logic [7:0]  got_q[$];
  int          errs_seen = 0;
  int          mon_bad = 0;
  int          cyc = 0;
  logic        prev_add = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      if (alu_inst != 4'd0) begin
        iss_q.push_back({alu_inst, alu_in});
        iss_cyc.push_back(cyc);
      end
      if (alu_inst > 4'd3) begin
        mon_bad++;
        $display("FAIL mon_illegal: alu_inst=%0h reached the ALU", alu_inst);
      end
      if (prev_add && alu_inst != 4'd0) begin
        mon_bad++;
        $display("FAIL mon_wait: alu_inst=%0h after ADD, required 0", alu_inst);
      end
      if (cmd_err) errs_seen++;
      if (res_valid && res_ready) got_q.push_back(res_data);
    end
    prev_add = (alu_inst == 4'd3);
    rnd_bit  = 1'($urandom_range(0, 1));
  end

  // Reference model: architectural A/B and the expected traffic.
  logic [7:0]  m_a = '0;
  logic [7:0]  m_b = '0;
  logic [11:0] exp_iss[$];
  logic [7:0]  exp_res[$];
  int          exp_errs = 0;

  function automatic void model(input logic [3:0] op, input logic [7:0] d);
    case (op)
      4'd0: ;
      4'd1: begin m_a = d; exp_iss.push_back({4'd1, d}); end
      4'd2: begin m_b = d; exp_iss.push_back({4'd2, d}); end
      4'd3: begin
        exp_iss.push_back({4'd3, 8'h00});
        exp_res.push_back(8'(m_a + m_b));
      end
      default: exp_errs++;
    endcase
  endfunction

  int checks = 0;
  int errors = 0;
  int rp_iss = 0;
  int rp_res = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [7:0] d);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && t < 500) begin
      tick();
      t++;
    end
    chk("push_timeout", int'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    model(op, d);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((busy || res_valid) && t < 500) begin
      tick();
      t++;
    end
    chk({tag, "_idle_timeout"}, int'(t < 500), 1);
  endtask

  task automatic wait_rv(input string tag);
    int t = 0;
    while (!res_valid && t < 200) begin
      tick();
      t++;
    end
    chk({tag, "_rv_timeout"}, int'(res_valid), 1);
  endtask

  task automatic check_all(input string tag);
    int ng = got_q.size() - rp_res;
    int ni = iss_q.size() - rp_iss;
    chk({tag, "_nres"}, ng, exp_res.size());
    for (int i = 0; i < exp_res.size() && i < ng; i++)
      chk({tag, "_res"}, int'(got_q[rp_res+i]), int'(exp_res[i]));
    chk({tag, "_niss"}, ni, exp_iss.size());
    for (int i = 0; i < exp_iss.size() && i < ni; i++)
      chk({tag, "_iss"}, int'(iss_q[rp_iss+i]), int'(exp_iss[i]));
    chk({tag, "_errs"}, errs_seen, exp_errs);
    chk({tag, "_mon"}, mon_bad, 0);
    rp_res = got_q.size();
    rp_iss = iss_q.size();
    exp_res.delete();
    exp_iss.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_inst", int'(alu_inst), 0);
    chk("rst_in", int'(alu_in), 0);
    chk("rst_rvalid", int'(res_valid), 0);
    chk("rst_rdata", int'(res_data), 0);
    chk("rst_err", int'(cmd_err), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", int'(cmd_ready), 1);

    // 1: simple add, loads back-to-back
    push(4'd1, 8'h05);
    push(4'd2, 8'h07);
    push(4'd3, 8'h00);
    wait_idle("t1");
    chk("t1_niss_raw", iss_q.size() - rp_iss, 3);
    if (iss_q.size() - rp_iss >= 3) begin
      chk("t1_b2b_ab", iss_cyc[rp_iss+1] - iss_cyc[rp_iss], 1);
      chk("t1_b2b_badd", iss_cyc[rp_iss+2] - iss_cyc[rp_iss+1], 1);
    end
    chk("t1_sum", (got_q.size() > rp_res) ? int'(got_q[rp_res]) : -1, 'h0C);
    check_all("t1");

    // 2: wrap-around add
    push(4'd1, 8'hF0);
    push(4'd2, 8'h20);
    push(4'd3, 8'h00);
    wait_idle("t2");
    chk("t2_sum", (got_q.size() > rp_res) ? int'(got_q[rp_res]) : -1, 'h10);
    check_all("t2");

    // 3: fill the FIFO while a result is held
    rr_val = 1'b0;
    push(4'd1, 8'h01);
    push(4'd2, 8'h02);
    push(4'd3, 8'h00);
    wait_rv("t3");
    push(4'd1, 8'h03);
    push(4'd2, 8'h04);
    push(4'd3, 8'h00);
    push(4'd1, 8'h09);
    chk("t3_full", int'(cmd_ready), 0);
    chk("t3_busy", int'(busy), 1);
    cmd_valid = 1'b1;
    cmd_op    = 4'd1;
    cmd_data  = 8'hEE;
    repeat (3) begin
      tick();
      chk("t3_refuse", int'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    rr_val = 1'b1;
    wait_idle("t3");
    check_all("t3");

    // 4: illegal and NOP filtered
    push(4'd9, 8'h55);
    push(4'd0, 8'h66);
    push(4'd1, 8'h11);
    wait_idle("t4");
    check_all("t4");

    // 5: result held under backpressure, no issue meanwhile
    rr_val = 1'b0;
    push(4'd1, 8'h33);
    push(4'd2, 8'h44);
    push(4'd3, 8'h00);
    wait_rv("t5");
    push(4'd1, 8'h01);
    repeat (10) begin
      tick();
      chk("t5_valid", int'(res_valid), 1);
      chk("t5_data", int'(res_data), 'h77);
      chk("t5_inst", int'(alu_inst), 0);
    end
    rr_val = 1'b1;
    wait_idle("t5");
    check_all("t5");

    // 6: reset while waiting for the ALU result
    push(4'd1, 8'h0A);
    push(4'd2, 8'h0B);
    push(4'd3, 8'h00);
    begin
      int t = 0;
      while (alu_inst != 4'd3 && t < 50) begin
        tick();
        t++;
      end
    end
    chk("t6_add_issue", int'(alu_inst), 3);
    tick();
    reset = 1'b1;
    tick();
    chk("t6_rvalid", int'(res_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_inst", int'(alu_inst), 0);
    chk("t6_ready", int'(cmd_ready), 1);
    reset = 1'b0;
    void'(exp_res.pop_back());
    repeat (5) tick();
    check_all("t6");

    // Randomized commands with random result backpressure
    rr_mode = 1'b1;
    repeat (60) begin
      int r = int'($urandom_range(0, 15));
      logic [3:0] op = (r < 12) ? 4'(r % 4) : 4'(r);
      push(op, 8'($urandom));
    end
    rr_mode = 1'b0;
    rr_val  = 1'b1;
    wait_idle("rnd");
    check_all("rnd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
